// File: rtl/attn_pkg.sv
// Shared definitions for the attention datapath.
// Element geometry defaults and the loader state type.
package attn_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_N     = 8;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } ld_state_t;

endpackage

// File: rtl/min_vector_loader.sv
// Packs N words into the FindMin vector, runs FindMin and
// returns the captured minimum over a valid/ready stream.
module min_vector_loader
    import attn_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic [WIDTH*N-1:0] numbers,
    output logic               start,
    input  logic               done,
    input  logic [WIDTH-1:0]   result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_min
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    ld_state_t          r_state;
    ld_state_t          w_next;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH*N-1:0] r_numbers;
    logic [WIDTH-1:0]   r_out_min;
    logic               r_in_ready;
    logic               r_start;
    logic               r_out_valid;
    logic               w_accept;
    logic               w_capture;

    // r_in_ready is only ever high in FILL, so it doubles as the state gate
    assign w_accept  = in_valid && r_in_ready && !flush;
    assign w_capture = (r_state == RUN) && done && !flush;

    // Next-state selection; flush overrides every other event
    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = FILL;
        end else begin
            unique case (r_state)
                FILL: if (w_accept && (r_cnt == LAST)) w_next = RUN;
                RUN:  if (done) w_next = OUT;
                OUT:  if (out_ready) w_next = FILL;
                default: w_next = FILL;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FILL;
        else        r_state <= w_next;
    end

    // Handshake outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b0;
            r_start     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_next == FILL);
            r_start     <= (w_next == RUN);
            r_out_valid <= (w_next == OUT);
        end
    end

    // Element write pointer, wrapping only after the last element
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    // Packer: each accepted word lands in its element slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_numbers <= '0;
        end else if (w_accept) begin
            r_numbers[WIDTH*r_cnt +: WIDTH] <= in_data;
        end
    end

    // Capture the FindMin result on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_min <= '0;
        end else if (w_capture) begin
            r_out_min <= result;
        end
    end

    assign in_ready  = r_in_ready;
    assign start     = r_start;
    assign out_valid = r_out_valid;
    assign out_min   = r_out_min;
    assign numbers   = r_numbers;

endmodule
